branch_redirect_arbiter: RTL and testbench



---
 rtl/branch_redirect_arbiter_pkg.sv | 33 +++
 rtl/branch_redirect_arbiter_if.sv | 35 +++
 rtl/branch_redirect_arbiter_rob_age_select.sv | 44 ++++
 rtl/branch_redirect_arbiter.sv | 98 +++++++++
 tb/tb_branch_redirect_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_redirect_arbiter_pkg.sv
// Shared types and ROB age helper for the branch redirect path.
package branch_redirect_arbiter_pkg;

   localparam int unsigned ALU_NUM    = 4;
   localparam int unsigned ROB_IDX_W  = 7;
   localparam int unsigned VADDR_W    = 39;
   localparam int unsigned FSQ_IDX_W  = 5;
   localparam int unsigned ROB_SLOT_W = ROB_IDX_W - 1;
   localparam int unsigned LANE_W     = (ALU_NUM > 1) ? $clog2(ALU_NUM) : 1;

   typedef struct packed {
      logic                  flag;
      logic [ROB_SLOT_W-1:0] idx;
   } rob_idx_t;

   typedef struct packed {
      rob_idx_t              rob_idx;
      logic [FSQ_IDX_W-1:0]  fsq_idx;
      logic [VADDR_W-1:0]    target;
      logic                  taken;
   } branch_redirect_t;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      PENDING    = 1'b1
   } arb_state_e;

   // True when a is strictly older than b; the flag bit disambiguates wrap.
   function automatic logic older(input rob_idx_t a, input rob_idx_t b);
      return (a.flag == b.flag) ? (a.idx < b.idx) : (a.idx > b.idx);
   endfunction

endpackage

// File: rtl/branch_redirect_arbiter_if.sv
// Branch resolution lanes in, single redirect out, plus flush/recovery controls.
interface branch_redirect_arbiter_if;
   import branch_redirect_arbiter_pkg::*;

   logic [ALU_NUM-1:0]           br_valid;
   logic [ALU_NUM-1:0]           br_error;
   logic [ALU_NUM*ROB_IDX_W-1:0] br_robidx;
   logic [ALU_NUM*FSQ_IDX_W-1:0] br_fsqidx;
   logic [ALU_NUM*VADDR_W-1:0]   br_target;
   logic [ALU_NUM-1:0]           br_taken;
   logic                         rob_flush;
   logic                         recover_done;
   logic                         redirect_valid;
   logic                         redirect_ready;
   logic [ROB_IDX_W-1:0]         redirect_robidx;
   logic [FSQ_IDX_W-1:0]         redirect_fsqidx;
   logic [VADDR_W-1:0]           redirect_target;
   logic                         redirect_taken;
   logic                         squash_active;

   modport slave (
      input  br_valid, br_error, br_robidx, br_fsqidx, br_target, br_taken,
      input  rob_flush, recover_done, redirect_ready,
      output redirect_valid, redirect_robidx, redirect_fsqidx, redirect_target,
      output redirect_taken, squash_active
   );

   modport master (
      output br_valid, br_error, br_robidx, br_fsqidx, br_target, br_taken,
      output rob_flush, recover_done, redirect_ready,
      input  redirect_valid, redirect_robidx, redirect_fsqidx, redirect_target,
      input  redirect_taken, squash_active
   );

endinterface

// File: rtl/branch_redirect_arbiter_rob_age_select.sv
// Log-depth oldest-of-N selector over ROB indices; ties resolve to the lower lane.
module rob_age_select
   import branch_redirect_arbiter_pkg::*;
#(
   parameter  int unsigned N     = ALU_NUM,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     valid_i,
   input  rob_idx_t [N-1:0] age_i,
   output logic [N-1:0]     onehot_o,
   output logic [IDX_W-1:0] index_o
);

   localparam int unsigned LEVELS = (N > 1) ? $clog2(N) : 0;
   localparam int unsigned NP     = 1 << LEVELS;
   localparam int unsigned NODES  = 2 * NP - 1;

   // Heap-ordered reduction tree: leaves at NP-1.., root at node 0.
   always_comb begin : sel_tree
      logic              nv [NODES];
      rob_idx_t          na [NODES];
      logic [IDX_W-1:0]  ni [NODES];
      logic              take_r;
      for (int i = 0; i < int'(NODES); i++) begin
         nv[i] = 1'b0;
         na[i] = '0;
         ni[i] = '0;
      end
      for (int i = 0; i < int'(N); i++) begin
         nv[int'(NP) - 1 + i] = valid_i[i];
         na[int'(NP) - 1 + i] = age_i[i];
         ni[int'(NP) - 1 + i] = IDX_W'(i);
      end
      for (int k = int'(NP) - 2; k >= 0; k--) begin
         take_r = nv[2*k+2] && (!nv[2*k+1] || older(na[2*k+2], na[2*k+1]));
         nv[k]  = nv[2*k+1] | nv[2*k+2];
         na[k]  = take_r ? na[2*k+2] : na[2*k+1];
         ni[k]  = take_r ? ni[2*k+2] : ni[2*k+1];
      end
      index_o  = ni[0];
      onehot_o = nv[0] ? (N'(1) << ni[0]) : '0;
   end

endmodule

// File: rtl/branch_redirect_arbiter.sv
// Holds the oldest mispredicting branch as a pending redirect and squashes younger results.
module branch_redirect_arbiter
   import branch_redirect_arbiter_pkg::*;
(
   input logic                     clk,
   input logic                     rst,
   branch_redirect_arbiter_if.slave arb_if
);

   arb_state_e                     state_q, state_d;
   branch_redirect_t               pend_q, pend_d;
   logic                           bnd_v_q, bnd_v_d;
   rob_idx_t                       bnd_q, bnd_d;

   branch_redirect_t [ALU_NUM-1:0] lane_br;
   rob_idx_t [ALU_NUM-1:0]         lane_rob;
   logic [ALU_NUM-1:0]             lane_keep;
   logic [ALU_NUM-1:0]             sel_onehot;
   logic [LANE_W-1:0]              sel_idx;
   logic                           sel_any;
   logic                           pend_valid;
   logic                           hs_fire;

   assign pend_valid = (state_q == PENDING);
   assign hs_fire    = pend_valid && arb_if.redirect_ready;
   assign sel_any    = |sel_onehot;

   // Unpack lanes and drop candidates not strictly older than pending/boundary.
   always_comb begin
      for (int i = 0; i < int'(ALU_NUM); i++) begin
         lane_br[i].rob_idx = arb_if.br_robidx[i*ROB_IDX_W +: ROB_IDX_W];
         lane_br[i].fsq_idx = arb_if.br_fsqidx[i*FSQ_IDX_W +: FSQ_IDX_W];
         lane_br[i].target  = arb_if.br_target[i*VADDR_W +: VADDR_W];
         lane_br[i].taken   = arb_if.br_taken[i];
         lane_rob[i]        = arb_if.br_robidx[i*ROB_IDX_W +: ROB_IDX_W];
         lane_keep[i]       = arb_if.br_valid[i] && arb_if.br_error[i]
                           && (!pend_valid || older(lane_rob[i], pend_q.rob_idx))
                           && (!bnd_v_q    || older(lane_rob[i], bnd_q));
      end
   end

   rob_age_select #(.N(ALU_NUM)) u_age_sel (
      .valid_i  (lane_keep),
      .age_i    (lane_rob),
      .onehot_o (sel_onehot),
      .index_o  (sel_idx)
   );

   // Next-state: flush wins, then acceptance/boundary update, then candidate capture.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      bnd_v_d = bnd_v_q;
      bnd_d   = bnd_q;
      if (arb_if.rob_flush) begin
         state_d = HOLD_EMPTY;
         pend_d  = '0;
         bnd_v_d = 1'b0;
         bnd_d   = '0;
      end else begin
         if (hs_fire) begin
            bnd_v_d = 1'b1;
            bnd_d   = pend_q.rob_idx;
         end else if (arb_if.recover_done) begin
            bnd_v_d = 1'b0;
         end
         if (sel_any) begin
            state_d = PENDING;
            pend_d  = lane_br[sel_idx];
         end else if (hs_fire) begin
            state_d = HOLD_EMPTY;
         end
      end
   end

   // State, pending entry and squash boundary registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= HOLD_EMPTY;
         pend_q  <= '0;
         bnd_v_q <= 1'b0;
         bnd_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         bnd_v_q <= bnd_v_d;
         bnd_q   <= bnd_d;
      end
   end

   assign arb_if.redirect_valid  = pend_valid;
   assign arb_if.redirect_robidx = pend_q.rob_idx;
   assign arb_if.redirect_fsqidx = pend_q.fsq_idx;
   assign arb_if.redirect_target = pend_q.target;
   assign arb_if.redirect_taken  = pend_q.taken;
   assign arb_if.squash_active   = bnd_v_q;

endmodule

// File: tb/tb_branch_redirect_arbiter.sv
// Scoreboard bench: directed scenarios followed by randomized lanes against a reference model.
module tb_branch_redirect_arbiter;
   import branch_redirect_arbiter_pkg::*;

   typedef struct packed {
      logic                 v;
      logic [ROB_IDX_W-1:0] rob;
      logic [FSQ_IDX_W-1:0] fsq;
      logic [VADDR_W-1:0]   tgt;
      logic                 tk;
      logic                 sq;
      logic                 all;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_redirect_arbiter_if bif();

   branch_redirect_arbiter dut (
      .clk    (clk),
      .rst    (rst),
      .arb_if (bif)
   );

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference state: pending redirect and squash boundary.
   logic                 m_pv = 1'b0;
   logic [ROB_IDX_W-1:0] m_prob = '0;
   logic [FSQ_IDX_W-1:0] m_pfsq = '0;
   logic [VADDR_W-1:0]   m_ptgt = '0;
   logic                 m_ptk = 1'b0;
   logic                 m_bv = 1'b0;
   logic [ROB_IDX_W-1:0] m_brob = '0;

   // a is older than b when b lies 1..63 entries ahead of a on the 128-entry ring.
   function automatic logic m_older(input logic [ROB_IDX_W-1:0] a, input logic [ROB_IDX_W-1:0] b);
      logic [ROB_IDX_W-1:0] d;
      d = b - a;
      return (d != '0) && (d < ROB_IDX_W'(1 << (ROB_IDX_W - 1)));
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one clock: model the edge, then queue what the DUT should show after it.
   task automatic cycle();
      exp_t                 e;
      logic                 npv, nbv, acc;
      logic [ROB_IDX_W-1:0] nprob, nbrob, c, best_rob;
      logic [FSQ_IDX_W-1:0] npfsq;
      logic [VADDR_W-1:0]   nptgt;
      logic                 nptk;
      int                   best;
      npv = m_pv; nprob = m_prob; npfsq = m_pfsq; nptgt = m_ptgt; nptk = m_ptk;
      nbv = m_bv; nbrob = m_brob;
      e.all = 1'b0;
      if (!rst) begin
         npv = 0; nprob = '0; npfsq = '0; nptgt = '0; nptk = 0; nbv = 0; nbrob = '0;
         e.all = 1'b1;
      end else if (bif.rob_flush) begin
         npv = 0; nbv = 0;
      end else begin
         acc = m_pv && bif.redirect_ready;
         best = -1;
         best_rob = '0;
         for (int i = 0; i < int'(ALU_NUM); i++) begin
            c = bif.br_robidx[i*ROB_IDX_W +: ROB_IDX_W];
            if (bif.br_valid[i] && bif.br_error[i]
                && (!m_pv || m_older(c, m_prob)) && (!m_bv || m_older(c, m_brob))
                && (best < 0 || m_older(c, best_rob))) begin
               best = i;
               best_rob = c;
            end
         end
         if (acc) begin
            nbv = 1; nbrob = m_prob;
         end else if (bif.recover_done) begin
            nbv = 0;
         end
         if (best >= 0) begin
            npv = 1; nprob = best_rob;
            npfsq = bif.br_fsqidx[best*FSQ_IDX_W +: FSQ_IDX_W];
            nptgt = bif.br_target[best*VADDR_W +: VADDR_W];
            nptk  = bif.br_taken[best];
         end else if (acc) begin
            npv = 0;
         end
      end
      e.v = npv; e.rob = nprob; e.fsq = npfsq; e.tgt = nptgt; e.tk = nptk; e.sq = nbv;
      @(posedge clk);
      exp_q.push_back(e);
      m_pv = npv; m_prob = nprob; m_pfsq = npfsq; m_ptgt = nptgt; m_ptk = nptk;
      m_bv = nbv; m_brob = nbrob;
      #1;
   endtask

   task automatic clear_lanes();
      bif.br_valid = '0; bif.br_error = '0; bif.br_robidx = '0;
      bif.br_fsqidx = '0; bif.br_target = '0; bif.br_taken = '0;
   endtask

   task automatic drive_lane(input int l, input logic [ROB_IDX_W-1:0] rob, input logic [VADDR_W-1:0] tgt);
      bif.br_valid[l] = 1'b1;
      bif.br_error[l] = 1'b1;
      bif.br_robidx[l*ROB_IDX_W +: ROB_IDX_W] = rob;
      bif.br_fsqidx[l*FSQ_IDX_W +: FSQ_IDX_W] = FSQ_IDX_W'(rob) ^ FSQ_IDX_W'(l);
      bif.br_target[l*VADDR_W +: VADDR_W] = tgt;
      bif.br_taken[l] = rob[0];
   endtask

   task automatic flush_cycle();
      bif.rob_flush = 1'b1;
      cycle();
      bif.rob_flush = 1'b0;
   endtask

   // Monitor: compare every presented output cycle against the queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("sb_valid", 64'(bif.redirect_valid), 64'(mon_e.v));
         chk("sb_squash", 64'(bif.squash_active), 64'(mon_e.sq));
         if (mon_e.v || mon_e.all) begin
            chk("sb_robidx", 64'(bif.redirect_robidx), 64'(mon_e.rob));
            chk("sb_fsqidx", 64'(bif.redirect_fsqidx), 64'(mon_e.fsq));
            chk("sb_target", 64'(bif.redirect_target), 64'(mon_e.tgt));
            chk("sb_taken", 64'(bif.redirect_taken), 64'(mon_e.tk));
         end
      end
   end

   initial begin
      logic [ROB_IDX_W-1:0] head;
      rst = 1'b0;
      clear_lanes();
      bif.rob_flush = 1'b0; bif.recover_done = 1'b0; bif.redirect_ready = 1'b0;
      #1;
      cycle();
      chk("reset_valid", 64'(bif.redirect_valid), 64'd0);
      chk("reset_squash", 64'(bif.squash_active), 64'd0);
      cycle();
      rst = 1'b1;

      // Single mispredict accepted immediately.
      bif.redirect_ready = 1'b1;
      drive_lane(2, 7'h05, 39'h80000100);
      cycle(); clear_lanes();
      chk("single_valid", 64'(bif.redirect_valid), 64'd1);
      chk("single_rob", 64'(bif.redirect_robidx), 64'h05);
      chk("single_target", 64'(bif.redirect_target), 64'h80000100);
      cycle();
      chk("single_after_valid", 64'(bif.redirect_valid), 64'd0);
      chk("single_after_squash", 64'(bif.squash_active), 64'd1);
      bif.redirect_ready = 1'b0; bif.recover_done = 1'b1;
      cycle(); bif.recover_done = 1'b0;
      chk("recover_clears", 64'(bif.squash_active), 64'd0);

      // Oldest pick across flags, then the wrap case.
      drive_lane(0, 7'h42, 39'h1000); drive_lane(1, 7'h3E, 39'h2000); drive_lane(3, 7'h10, 39'h3000);
      cycle(); clear_lanes();
      chk("oldest_pick", 64'(bif.redirect_robidx), 64'h10);
      flush_cycle();
      drive_lane(0, 7'h42, 39'h1000); drive_lane(1, 7'h3E, 39'h2000);
      cycle(); clear_lanes();
      chk("wrap_pick", 64'(bif.redirect_robidx), 64'h3E);
      flush_cycle();

      // Back-pressure: older replaces, younger ignored.
      drive_lane(2, 7'h20, 39'h4000); cycle(); clear_lanes();
      drive_lane(1, 7'h18, 39'h5000); cycle(); clear_lanes();
      chk("bp_replace", 64'(bif.redirect_robidx), 64'h18);
      drive_lane(0, 7'h30, 39'h6000); cycle(); clear_lanes();
      chk("bp_hold_rob", 64'(bif.redirect_robidx), 64'h18);
      chk("bp_hold_target", 64'(bif.redirect_target), 64'h5000);
      flush_cycle();

      // Boundary filtering and release.
      drive_lane(1, 7'h20, 39'h7000); cycle(); clear_lanes();
      bif.redirect_ready = 1'b1; cycle(); bif.redirect_ready = 1'b0;
      chk("bnd_squash", 64'(bif.squash_active), 64'd1);
      drive_lane(2, 7'h25, 39'h7100); cycle(); clear_lanes();
      chk("bnd_drop", 64'(bif.redirect_valid), 64'd0);
      drive_lane(3, 7'h1F, 39'h7200); cycle(); clear_lanes();
      chk("bnd_older_rob", 64'(bif.redirect_robidx), 64'h1F);
      bif.redirect_ready = 1'b1; cycle(); bif.redirect_ready = 1'b0;
      bif.recover_done = 1'b1; cycle(); bif.recover_done = 1'b0;
      chk("bnd_release", 64'(bif.squash_active), 64'd0);
      drive_lane(0, 7'h25, 39'h7300); cycle(); clear_lanes();
      chk("post_recover_valid", 64'(bif.redirect_valid), 64'd1);
      chk("post_recover_rob", 64'(bif.redirect_robidx), 64'h25);

      // Flush beats handshake and a simultaneous candidate.
      bif.redirect_ready = 1'b1; bif.rob_flush = 1'b1; drive_lane(1, 7'h01, 39'h7400);
      cycle(); clear_lanes(); bif.rob_flush = 1'b0; bif.redirect_ready = 1'b0;
      chk("flush_valid", 64'(bif.redirect_valid), 64'd0);
      chk("flush_squash", 64'(bif.squash_active), 64'd0);

      // Reset while pending.
      drive_lane(0, 7'h30, 39'h7500); cycle(); clear_lanes();
      rst = 1'b0; cycle(); rst = 1'b1;
      chk("midrst_valid", 64'(bif.redirect_valid), 64'd0);
      chk("midrst_target", 64'(bif.redirect_target), 64'd0);
      drive_lane(2, 7'h31, 39'h7600); cycle(); clear_lanes();
      chk("midrst_resume", 64'(bif.redirect_robidx), 64'h31);

      // Randomized traffic within a legal ROB window that wraps over time.
      head = 7'h60;
      repeat (3000) begin
         rst = ($urandom_range(0, 199) != 0);
         bif.rob_flush = ($urandom_range(0, 39) == 0);
         bif.recover_done = ($urandom_range(0, 7) == 0);
         bif.redirect_ready = $urandom_range(0, 1) == 1;
         for (int l = 0; l < int'(ALU_NUM); l++) begin
            bif.br_valid[l] = $urandom_range(0, 1) == 1;
            bif.br_error[l] = ($urandom_range(0, 2) == 0);
            bif.br_robidx[l*ROB_IDX_W +: ROB_IDX_W] = head + ROB_IDX_W'($urandom_range(0, 40));
            bif.br_fsqidx[l*FSQ_IDX_W +: FSQ_IDX_W] = FSQ_IDX_W'($urandom);
            bif.br_target[l*VADDR_W +: VADDR_W] = VADDR_W'({$urandom, $urandom});
            bif.br_taken[l] = $urandom_range(0, 1) == 1;
         end
         cycle();
         if (!m_pv && !m_bv) head = head + ROB_IDX_W'($urandom_range(0, 12));
      end
      rst = 1'b1; bif.rob_flush = 1'b0; bif.recover_done = 1'b0; clear_lanes();
      cycle();
      @(negedge clk); #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
